// File: rtl/mc_control_if.sv
// Memory handshake bundle between the multi-cycle controller and its fetch/data ports.
// Latency: none, plain wires grouped for port connection.
// Backpressure: requests stay asserted until the matching *_ready_i is seen high.
interface mc_control_if;
    logic       imem_req_o;
    logic       imem_ready_i;
    logic       dmem_req_o;
    logic       dmem_we_o;
    logic [1:0] dmem_size_o;
    logic       dmem_ready_i;

    // Controller side drives requests and samples readies.
    modport master (
        output imem_req_o,
        input  imem_ready_i,
        output dmem_req_o,
        output dmem_we_o,
        output dmem_size_o,
        input  dmem_ready_i
    );

    // Memory side answers requests with ready.
    modport slave (
        input  imem_req_o,
        output imem_ready_i,
        input  dmem_req_o,
        input  dmem_we_o,
        input  dmem_size_o,
        output dmem_ready_i
    );
endinterface

// File: rtl/mc_control.sv
// Multi-cycle CPU control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP); MC_CONTROL_ILLEGAL_TRAP_EN enables TRAP.
// Latency: zero-wait R/I/J 4 cycles, B 3, S 4, L 5; outputs are combinational from state and inputs.
// Backpressure: FETCH/MEM hold their request until ready; 2^TIMEOUT_W-1 unacknowledged cycles abort with bus_err_o.
module mc_control #(
    parameter int TIMEOUT_W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [2:0]   op_i,
    input  logic [2:0]   func2_i,
    input  logic         branch_taken_i,
    mc_control_if.master bus,
    output logic         ir_we_o,
    output logic         pc_we_o,
    output logic [1:0]   pc_sel_o,
    output logic         rf_we_o,
    output logic [1:0]   wb_sel_o,
    output logic         alu_src_o,
    output logic [2:0]   state_o,
    output logic         retire_o,
    output logic         bus_err_o,
    output logic         trap_o
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    localparam logic [2:0] OP_R = 3'b000;
    localparam logic [2:0] OP_I = 3'b001;
    localparam logic [2:0] OP_L = 3'b010;
    localparam logic [2:0] OP_S = 3'b011;
    localparam logic [2:0] OP_B = 3'b100;
    localparam logic [2:0] OP_J = 3'b101;

    localparam logic [1:0] PC_SEL_SEQ = 2'd0;
    localparam logic [1:0] PC_SEL_BR  = 2'd1;
    localparam logic [1:0] PC_SEL_JMP = 2'd2;

    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_LOAD = 2'd1;
    localparam logic [1:0] WB_SEL_LINK = 2'd2;

    // Wait limit is the all-ones value of the counter.
    localparam logic [TIMEOUT_W-1:0] WAIT_LIMIT = '1;

    // Where an abandoned (timed-out) transaction goes next.
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
    localparam state_t ABORT_STATE = TRAP;
`else
    localparam state_t ABORT_STATE = FETCH;
`endif

    state_t               state_q;
    state_t               state_d;
    logic [TIMEOUT_W-1:0] wait_q;
    logic [TIMEOUT_W-1:0] wait_d;
    logic                 wait_expired;

    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic [1:0] dmem_size;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic       alu_src;
    logic       retire;
    logic       bus_err;

    // Only the low two qualifier bits carry the access size.
    logic unused_func2;
    assign unused_func2 = func2_i[2];

    // The counter holds the number of unacknowledged request cycles so far.
    assign wait_expired = (wait_q == WAIT_LIMIT);

    // State and wait-counter registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state, wait-counter and control decode for the current state.
    always_comb begin
        state_d   = state_q;
        wait_d    = '0;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        dmem_size = 2'd0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = PC_SEL_SEQ;
        rf_we     = 1'b0;
        wb_sel    = WB_SEL_ALU;
        alu_src   = 1'b0;
        retire    = 1'b0;
        bus_err   = 1'b0;

        case (state_q)
            FETCH: begin
                imem_req = 1'b1;
                if (bus.imem_ready_i) begin
                    // Ready on the limit cycle still completes normally.
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    pc_sel  = PC_SEL_SEQ;
                    state_d = DECODE;
                end else if (wait_expired) begin
                    bus_err = 1'b1;
                    state_d = ABORT_STATE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            DECODE: begin
                case (op_i)
                    OP_R, OP_I, OP_L, OP_S, OP_B, OP_J: state_d = EXEC;
                    default: begin
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
                        state_d = TRAP;
`else
                        // Unassigned opcodes retire as NOPs.
                        retire  = 1'b1;
                        state_d = FETCH;
`endif
                    end
                endcase
            end

            EXEC: begin
                case (op_i)
                    OP_R: begin
                        alu_src = 1'b0;
                        state_d = WB;
                    end
                    OP_I: begin
                        alu_src = 1'b1;
                        state_d = WB;
                    end
                    OP_L, OP_S: begin
                        // Address = base + immediate.
                        alu_src = 1'b1;
                        state_d = MEM;
                    end
                    OP_B: begin
                        alu_src = 1'b0;
                        pc_we   = branch_taken_i;
                        pc_sel  = PC_SEL_BR;
                        retire  = 1'b1;
                        state_d = FETCH;
                    end
                    OP_J: begin
                        pc_we   = 1'b1;
                        pc_sel  = PC_SEL_JMP;
                        state_d = WB;
                    end
                    default: state_d = FETCH;
                endcase
            end

            MEM: begin
                dmem_req  = 1'b1;
                dmem_we   = (op_i == OP_S);
                dmem_size = func2_i[1:0];
                if (bus.dmem_ready_i) begin
                    if (op_i == OP_S) begin
                        retire  = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end else if (wait_expired) begin
                    bus_err = 1'b1;
                    state_d = ABORT_STATE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            WB: begin
                rf_we = 1'b1;
                if (op_i == OP_L) begin
                    wb_sel = WB_SEL_LOAD;
                end else if (op_i == OP_J) begin
                    wb_sel = WB_SEL_LINK;
                end else begin
                    wb_sel = WB_SEL_ALU;
                end
                retire  = 1'b1;
                state_d = FETCH;
            end

`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
            TRAP: begin
                // Parked until reset; all strobes stay at their defaults.
                state_d = TRAP;
            end
`endif

            default: state_d = FETCH;
        endcase
    end

    // Strobes are forced low while reset is held so no side effect escapes mid-reset.
    assign bus.imem_req_o  = imem_req & ~rst_i;
    assign bus.dmem_req_o  = dmem_req & ~rst_i;
    assign bus.dmem_we_o   = dmem_we  & ~rst_i;
    assign bus.dmem_size_o = dmem_size;
    assign ir_we_o         = ir_we    & ~rst_i;
    assign pc_we_o         = pc_we    & ~rst_i;
    assign rf_we_o         = rf_we    & ~rst_i;
    assign retire_o        = retire   & ~rst_i;
    assign bus_err_o       = bus_err  & ~rst_i;
    assign pc_sel_o        = pc_sel;
    assign wb_sel_o        = wb_sel;
    assign alu_src_o       = alu_src;
    assign state_o         = state_q;

`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
    assign trap_o = (state_q == TRAP);
`else
    assign trap_o = 1'b0;
`endif

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: instruction flows, wait/timeout boundaries, illegal opcode, reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Expectations follow the MC_CONTROL_ILLEGAL_TRAP_EN setting of the build.
module tb_mc_control;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] op  = 3'd0;
    logic [2:0] f2  = 3'd0;
    logic       bt  = 1'b0;

    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic       alu_src;
    logic [2:0] state;
    logic       retire;
    logic       bus_err;
    logic       trap;

    int checks   = 0;
    int failures = 0;

    mc_control_if bus ();

    mc_control #(.TIMEOUT_W(4)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .op_i           (op),
        .func2_i        (f2),
        .branch_taken_i (bt),
        .bus            (bus),
        .ir_we_o        (ir_we),
        .pc_we_o        (pc_we),
        .pc_sel_o       (pc_sel),
        .rf_we_o        (rf_we),
        .wb_sel_o       (wb_sel),
        .alu_src_o      (alu_src),
        .state_o        (state),
        .retire_o       (retire),
        .bus_err_o      (bus_err),
        .trap_o         (trap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    task automatic do_fetch(input logic [2:0] opc);
        op = opc;
        bus.imem_ready_i = 1'b1;
        smp;
        chk("fetch_state", state, 8'd0);
        chk("fetch_imem_req", bus.imem_req_o, 8'd1);
        chk("fetch_ir_we", ir_we, 8'd1);
        chk("fetch_pc_we", pc_we, 8'd1);
        chk("fetch_pc_sel", pc_sel, 8'd0);
        chk("fetch_retire", retire, 8'd0);
        cyc;
    endtask

    task automatic do_decode;
        smp;
        chk("decode_state", state, 8'd1);
        chk("decode_pc_we", pc_we, 8'd0);
        chk("decode_retire", retire, 8'd0);
        cyc;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        cyc;
        rst = 1'b0;
    endtask

    initial begin
        bus.imem_ready_i = 1'b0;
        bus.dmem_ready_i = 1'b0;

        // Reset state, strobes forced low while reset is high
        cyc;
        smp;
        chk("rst_state", state, 8'd0);
        chk("rst_imem_req", bus.imem_req_o, 8'd0);
        chk("rst_trap", trap, 8'd0);
        chk("rst_bus_err", bus_err, 8'd0);
        cyc;
        rst = 1'b0;

        // R op: states 0,1,2,4 then back to 0
        do_fetch(3'b000);
        do_decode;
        smp;
        chk("r_exec_state", state, 8'd2);
        chk("r_exec_alu_src", alu_src, 8'd0);
        chk("r_exec_pc_we", pc_we, 8'd0);
        chk("r_exec_rf_we", rf_we, 8'd0);
        cyc;
        smp;
        chk("r_wb_state", state, 8'd4);
        chk("r_wb_rf_we", rf_we, 8'd1);
        chk("r_wb_sel", wb_sel, 8'd0);
        chk("r_wb_retire", retire, 8'd1);
        chk("r_wb_pc_we", pc_we, 8'd0);
        cyc;

        // I op: immediate operand
        do_fetch(3'b001);
        do_decode;
        smp;
        chk("i_exec_alu_src", alu_src, 8'd1);
        cyc;
        smp;
        chk("i_wb_rf_we", rf_we, 8'd1);
        chk("i_wb_sel", wb_sel, 8'd0);
        cyc;

        // L op, word size, dmem ready after 3 wait cycles
        f2 = 3'b010;
        do_fetch(3'b010);
        do_decode;
        smp;
        chk("l_exec_alu_src", alu_src, 8'd1);
        chk("l_exec_dmem_req", bus.dmem_req_o, 8'd0);
        cyc;
        bus.dmem_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            smp;
            chk("l_mem_state", state, 8'd3);
            chk("l_mem_req", bus.dmem_req_o, 8'd1);
            chk("l_mem_size", bus.dmem_size_o, 8'd2);
            chk("l_mem_we", bus.dmem_we_o, 8'd0);
            cyc;
        end
        bus.dmem_ready_i = 1'b1;
        smp;
        chk("l_mem_req_last", bus.dmem_req_o, 8'd1);
        chk("l_mem_retire", retire, 8'd0);
        cyc;
        bus.dmem_ready_i = 1'b0;
        smp;
        chk("l_wb_state", state, 8'd4);
        chk("l_wb_sel", wb_sel, 8'd1);
        chk("l_wb_rf_we", rf_we, 8'd1);
        chk("l_wb_dmem_req", bus.dmem_req_o, 8'd0);
        cyc;

        // S op, byte size, zero-wait: retires in MEM
        f2 = 3'b000;
        do_fetch(3'b011);
        do_decode;
        cyc;
        bus.dmem_ready_i = 1'b1;
        smp;
        chk("s_mem_state", state, 8'd3);
        chk("s_mem_we", bus.dmem_we_o, 8'd1);
        chk("s_mem_size", bus.dmem_size_o, 8'd0);
        chk("s_mem_retire", retire, 8'd1);
        chk("s_mem_rf_we", rf_we, 8'd0);
        cyc;
        bus.dmem_ready_i = 1'b0;

        // B taken then B not taken, each 3 cycles
        bt = 1'b1;
        do_fetch(3'b100);
        do_decode;
        smp;
        chk("bt_exec_pc_we", pc_we, 8'd1);
        chk("bt_exec_pc_sel", pc_sel, 8'd1);
        chk("bt_exec_alu_src", alu_src, 8'd0);
        chk("bt_exec_retire", retire, 8'd1);
        cyc;
        bt = 1'b0;
        do_fetch(3'b100);
        do_decode;
        smp;
        chk("bn_exec_pc_we", pc_we, 8'd0);
        chk("bn_exec_retire", retire, 8'd1);
        cyc;

        // J op: jump target in EXEC, link in WB
        do_fetch(3'b101);
        do_decode;
        smp;
        chk("j_exec_pc_we", pc_we, 8'd1);
        chk("j_exec_pc_sel", pc_sel, 8'd2);
        cyc;
        smp;
        chk("j_wb_sel", wb_sel, 8'd2);
        chk("j_wb_rf_we", rf_we, 8'd1);
        cyc;

        // imem ready arrives exactly on the limit cycle: no error
        op = 3'b001;
        bus.imem_ready_i = 1'b0;
        for (int i = 0; i < 15; i++) begin
            smp;
            chk("lim_wait_err", bus_err, 8'd0);
            cyc;
        end
        bus.imem_ready_i = 1'b1;
        smp;
        chk("lim_ready_err", bus_err, 8'd0);
        chk("lim_ready_ir_we", ir_we, 8'd1);
        cyc;
        smp;
        chk("lim_decode_state", state, 8'd1);
        cyc;
        cyc;
        smp;
        chk("lim_wb_retire", retire, 8'd1);
        cyc;

        // Opcode 111
        do_fetch(3'b111);
        smp;
        chk("ill_decode_state", state, 8'd1);
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
        chk("ill_decode_retire", retire, 8'd0);
        cyc;
        cyc;
        cyc;
        smp;
        chk("ill_trap_state", state, 8'd5);
        chk("ill_trap_o", trap, 8'd1);
        chk("ill_trap_imem_req", bus.imem_req_o, 8'd0);
`else
        chk("ill_decode_retire", retire, 8'd1);
        cyc;
        smp;
        chk("ill_back_state", state, 8'd0);
        chk("ill_trap_o", trap, 8'd0);
`endif
        do_reset;

        // imem timeout: 15 wait cycles, then error pulse
        bus.imem_ready_i = 1'b0;
        op = 3'b000;
        for (int i = 0; i < 15; i++) begin
            smp;
            chk("to_wait_err", bus_err, 8'd0);
            chk("to_wait_req", bus.imem_req_o, 8'd1);
            cyc;
        end
        smp;
        chk("to_err_pulse", bus_err, 8'd1);
        chk("to_err_ir_we", ir_we, 8'd0);
        cyc;
        smp;
        chk("to_after_err", bus_err, 8'd0);
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
        chk("to_after_state", state, 8'd5);
        chk("to_after_trap", trap, 8'd1);
`else
        chk("to_after_state", state, 8'd0);
        chk("to_after_req", bus.imem_req_o, 8'd1);
`endif
        do_reset;
        smp;
        chk("to_rst_state", state, 8'd0);
        chk("to_rst_trap", trap, 8'd0);
        do_reset;

        // dmem timeout on a load: abandoned with no write-back or retire
        f2 = 3'b001;
        do_fetch(3'b010);
        bus.imem_ready_i = 1'b0;
        do_decode;
        cyc;
        bus.dmem_ready_i = 1'b0;
        for (int i = 0; i < 15; i++) begin
            smp;
            chk("mto_wait_err", bus_err, 8'd0);
            cyc;
        end
        smp;
        chk("mto_err_pulse", bus_err, 8'd1);
        chk("mto_err_rf_we", rf_we, 8'd0);
        chk("mto_err_retire", retire, 8'd0);
        cyc;
        smp;
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
        chk("mto_after_state", state, 8'd5);
`else
        chk("mto_after_state", state, 8'd0);
`endif
        chk("mto_after_rf_we", rf_we, 8'd0);
        do_reset;

        // Reset during MEM of a store
        do_fetch(3'b011);
        bus.imem_ready_i = 1'b0;
        do_decode;
        cyc;
        smp;
        chk("srst_mem_req", bus.dmem_req_o, 8'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("srst_forced_req", bus.dmem_req_o, 8'd0);
        chk("srst_forced_we", bus.dmem_we_o, 8'd0);
        cyc;
        rst = 1'b0;
        smp;
        chk("srst_after_state", state, 8'd0);
        chk("srst_after_imem_req", bus.imem_req_o, 8'd1);
        chk("srst_after_dmem_req", bus.dmem_req_o, 8'd0);
        cyc;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 SHALL have parameter TIMEOUT_W, default 4, width of the memory-wait counter; timeout limit is 2^TIMEOUT_W-1 cycles.
REQ-002 SHALL have port clk_i  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports op_i  input  3 (opcode from decoder) and func2_i  input  3 (opcode qualifier from decoder).
REQ-005 SHALL have port branch_taken_i  input  1  branch condition result from datapath comparator.
REQ-006 SHALL have ports imem_req_o  output  1 and imem_ready_i  input  1 (instruction fetch handshake).
REQ-007 SHALL have ports dmem_req_o  output  1, dmem_we_o  output  1, dmem_size_o  output  2, and dmem_ready_i  input  1 (data memory handshake).
REQ-008 SHALL have port ir_we_o  output  1  instruction register load strobe.
REQ-009 SHALL have ports pc_we_o  output  1 and pc_sel_o  output  2 (0=PC+2, 1=branch target, 2=jump target).
REQ-010 SHALL have ports rf_we_o  output  1, wb_sel_o  output  2 (0=ALU, 1=load data, 2=PC link), and alu_src_o  output  1 (0=rs2, 1=imm).
REQ-011 SHALL have ports state_o  output  3, retire_o  output  1, bus_err_o  output  1, and trap_o  output  1.

Function
REQ-012 SHALL use states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; state_o SHALL equal the state register.
REQ-013 FETCH SHALL assert imem_req_o until imem_ready_i; on the ready cycle, ir_we_o=1, pc_we_o=1, pc_sel_o=0, and next state is DECODE.
REQ-014 DECODE SHALL last exactly 1 cycle, then enter EXEC for opcodes 000-101.
REQ-015 R (000) and I (001) SHALL follow EXEC->WB; alu_src_o SHALL be 0 for R and 1 for I during EXEC.
REQ-016 WB SHALL assert rf_we_o=1 for exactly one cycle with wb_sel_o per REQ-010, then enter FETCH.
REQ-017 L (010) SHALL follow EXEC->MEM->WB; S (011) SHALL follow EXEC->MEM->FETCH; alu_src_o SHALL be 1 in EXEC for both.
REQ-018 MEM SHALL assert dmem_req_o until dmem_ready_i, with dmem_we_o=1 for S and 0 for L.
REQ-019 In MEM, dmem_size_o SHALL equal func2_i[1:0].
REQ-020 B (100) SHALL execute EXEC->FETCH, with alu_src_o=0, pc_we_o=branch_taken_i, and pc_sel_o=1 in EXEC.
REQ-021 J (101) SHALL execute EXEC->WB, with pc_we_o=1 and pc_sel_o=2 in EXEC, and wb_sel_o=2 in WB.
REQ-022 retire_o SHALL pulse for 1 cycle on the final cycle of each instruction: WB, S/B EXEC->FETCH or MEM->FETCH, or NOP DECODE.
REQ-023 Zero-wait minimum latencies SHALL be: R/I/J 4 cycles, B 3 cycles, S 4 cycles, L 5 cycles.
REQ-024 A wait counter SHALL clear on entry to FETCH/MEM and increment each cycle a request is unacknowledged.
REQ-025 If the wait counter reaches the limit with ready still low, bus_err_o SHALL pulse 1 cycle and the instruction SHALL be abandoned without rf_we_o or retire_o.
REQ-026 If ready arrives on the same cycle the limit is reached, the handshake SHALL complete normally and bus_err_o SHALL stay 0.
REQ-027 All strobe outputs (*_req_o, *_we_o, retire_o, bus_err_o) SHALL be 0 in every state and cycle not listed above; selects SHALL be 0 when unused.

Reset
REQ-028 While rst_i=1 at a clock edge, the state SHALL become FETCH and the wait counter SHALL become 0.
REQ-029 While rst_i=1 at a clock edge, trap_o SHALL become 0.
REQ-030 While rst_i is high, all strobe outputs SHALL be forced to 0.
REQ-031 Reset asserted mid-handshake SHALL abandon the transaction; the first cycle after reset SHALL be FETCH with imem_req_o=1.

Configuration
REQ-032 Macro MC_CONTROL_ILLEGAL_TRAP_EN SHALL control illegal-opcode and timeout handling.
REQ-033 When MC_CONTROL_ILLEGAL_TRAP_EN is defined, opcodes 110/111 in DECODE SHALL enter TRAP.
REQ-034 When MC_CONTROL_ILLEGAL_TRAP_EN is defined, a timeout SHALL enter TRAP after the bus_err_o pulse.
REQ-035 TRAP SHALL hold trap_o=1 with all strobes 0 until reset.
REQ-036 When MC_CONTROL_ILLEGAL_TRAP_EN is undefined, opcodes 110/111 SHALL retire as NOP (DECODE->FETCH), TRAP SHALL be unreachable, trap_o SHALL be tied 0, and a timeout SHALL return to FETCH.

Verification
REQ-037 R op with imem_ready_i tied 1 -> states 0,1,2,4,0; one pc_we_o and one rf_we_o; retire_o on cycle 4.
REQ-038 L op with func2_i=010 and dmem_ready_i delayed 3 cycles -> dmem_req_o high 4 cycles, dmem_size_o=2, dmem_we_o=0, then WB with wb_sel_o=1.
REQ-039 B op with branch_taken_i=1, then a second B with branch_taken_i=0 -> EXEC pc_we_o=1 (pc_sel_o=1), then pc_we_o=0; each retires in 3 cycles.
REQ-040 imem_ready_i held 0 with TIMEOUT_W=4 -> bus_err_o pulse after 15 wait cycles; then FETCH with the macro off, or TRAP with trap_o=1 with the macro on.
REQ-041 Opcode 111 -> macro off: retire_o in DECODE and back to FETCH; macro on: state_o=5 and trap_o stays 1 until rst_i.
REQ-042 rst_i pulsed during MEM of an S op -> no further dmem_req_o; state_o=0 and imem_req_o=1 the cycle after reset deasserts.
